// File: rtl/rs_issue_select.sv
// Issue-select stage: round-robin pick of up to ISSUE_W ready RS lines into the
// issue/execute register, with a single non-pipelined multiplier hazard.
module rs_issue_select #(
  parameter int RS_SIZE  = 8,
  parameter int ISSUE_W  = 2,
  parameter int PKT_W    = 128,
  parameter int MULT_LAT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [RS_SIZE-1:0]         line_ready,
  input  logic [RS_SIZE-1:0]         line_is_mult,
  input  logic [RS_SIZE*PKT_W-1:0]   line_pkt,
  input  logic                       ex_stall,
  input  logic                       squash,
  output logic [RS_SIZE-1:0]         clear_line,
  output logic [ISSUE_W-1:0]         is_valid,
  output logic [ISSUE_W*PKT_W-1:0]   is_pkt,
  output logic [ISSUE_W-1:0]         is_mult,
  output logic                       mult_busy
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = $clog2(MULT_LAT) + 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);

  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] mult_cnt;

  logic               gen;
  logic [PKT_W-1:0]   pkt_arr [RS_SIZE];
  logic [RS_SIZE-1:0] grant;
  logic [IDX_W-1:0]   slot_idx [ISSUE_W];
  logic [ISSUE_W-1:0] slot_vld;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_idx;
  logic               mult_taken;
  logic               any_grant;
  int                 n_grant;
  logic [ISSUE_W*PKT_W-1:0] nxt_pkt;
  logic [ISSUE_W-1:0]       nxt_mult;

  assign gen       = !ex_stall && !squash && !reset;
  assign mult_busy = (mult_cnt != '0);
  assign clear_line = grant;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      pkt_arr[i] = line_pkt[i*PKT_W +: PKT_W];
    end
  end

  // Scan every line once starting at rr_ptr; RS_SIZE is a power of two so the
  // index wraps naturally in IDX_W bits.
  always_comb begin
    grant      = '0;
    slot_vld   = '0;
    idx        = '0;
    last_idx   = rr_ptr;
    mult_taken = 1'b0;
    n_grant    = 0;
    for (int s = 0; s < ISSUE_W; s++) begin
      slot_idx[s] = '0;
    end
    for (int k = 0; k < RS_SIZE; k++) begin
      idx = rr_ptr + IDX_W'(k);
      if (gen && (n_grant < ISSUE_W) && line_ready[idx] &&
          (!line_is_mult[idx] || ((mult_cnt == '0) && !mult_taken))) begin
        grant[idx] = 1'b1;
        for (int s = 0; s < ISSUE_W; s++) begin
          if (s == n_grant) begin
            slot_idx[s] = idx;
            slot_vld[s] = 1'b1;
          end
        end
        n_grant = n_grant + 1;
        if (line_is_mult[idx]) mult_taken = 1'b1;
        last_idx = idx;
      end
    end
    any_grant = (n_grant != 0);
  end

  always_comb begin
    nxt_pkt  = '0;
    nxt_mult = '0;
    for (int s = 0; s < ISSUE_W; s++) begin
      if (slot_vld[s]) begin
        nxt_pkt[s*PKT_W +: PKT_W] = pkt_arr[slot_idx[s]];
        nxt_mult[s]               = line_is_mult[slot_idx[s]];
      end
    end
  end

  // Precedence: reset > squash > ex_stall > normal issue.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= '0;
      mult_cnt <= '0;
      is_valid <= '0;
      is_pkt   <= '0;
      is_mult  <= '0;
    end else if (squash) begin
      is_valid <= '0;
      mult_cnt <= '0;
    end else if (ex_stall) begin
      if (mult_cnt != '0) mult_cnt <= mult_cnt - 1'b1;
    end else begin
      is_valid <= slot_vld;
      is_pkt   <= nxt_pkt;
      is_mult  <= nxt_mult;
      if (any_grant) rr_ptr <= last_idx + 1'b1;
      if (mult_taken)
        mult_cnt <= MULT_LOAD;
      else if (mult_cnt != '0)
        mult_cnt <= mult_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select: directed scenarios plus random traffic, checked
// against a timestamp-based reference model of the issue rules.
module tb_rs_issue_select;
  localparam int RS = 8;
  localparam int IW = 2;
  localparam int PW = 128;
  localparam int ML = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [RS-1:0]        line_ready;
  logic [RS-1:0]        line_is_mult;
  logic [RS*PW-1:0]     line_pkt;
  logic                 ex_stall;
  logic                 squash;
  logic [RS-1:0]        clear_line;
  logic [IW-1:0]        is_valid;
  logic [IW*PW-1:0]     is_pkt;
  logic [IW-1:0]        is_mult;
  logic                 mult_busy;

  rs_issue_select #(.RS_SIZE(RS), .ISSUE_W(IW), .PKT_W(PW), .MULT_LAT(ML)) dut (
    .clock(clock), .reset(reset), .line_ready(line_ready), .line_is_mult(line_is_mult),
    .line_pkt(line_pkt), .ex_stall(ex_stall), .squash(squash), .clear_line(clear_line),
    .is_valid(is_valid), .is_pkt(is_pkt), .is_mult(is_mult), .mult_busy(mult_busy)
  );

  // clock / watchdog
  always #5 clock = ~clock;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: rotating pointer as an integer, multiplier availability
  // as the first cycle number at which a multiply may be granted.
  logic [PW-1:0] pkts [RS];
  int            m_rr = 0;
  int            m_mult_ok = 0;
  int            cyc = 0;
  logic [RS-1:0] exp_clear, obs_clear;
  logic [IW-1:0] exp_valid = '0, exp_mult = '0;
  logic [PW-1:0] exp_pkt [IW];
  logic          exp_busy = 1'b0;
  logic [PW-1:0] exp_q [$];

  task automatic randomize_pkts();
    for (int i = 0; i < RS; i++) begin
      pkts[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      line_pkt[i*PW +: PW] = pkts[i];
    end
  endtask

  task automatic cycle();
    int now, n;
    bit g, took;
    int gl[$];
    logic [RS-1:0] mflags;
    @(negedge clock);
    obs_clear = clear_line;
    now = cyc;
    g = !ex_stall && !squash && !reset;
    mflags = line_is_mult;
    exp_clear = '0;
    took = 0;
    n = 0;
    if (g) begin
      for (int k = 0; k < RS; k++) begin
        int i;
        i = (m_rr + k) % RS;
        if (n < IW && line_ready[i] && (!mflags[i] || (now >= m_mult_ok && !took))) begin
          exp_clear[i] = 1'b1;
          gl.push_back(i);
          n++;
          if (mflags[i]) took = 1;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc = now + 1;
    if (reset) begin
      m_rr = 0;
      m_mult_ok = cyc;
      exp_valid = '0;
      exp_mult = '0;
      for (int s = 0; s < IW; s++) exp_pkt[s] = '0;
    end else if (squash) begin
      exp_valid = '0;
      m_mult_ok = cyc;
    end else if (!ex_stall) begin
      exp_valid = '0;
      for (int s = 0; s < gl.size(); s++) begin
        exp_valid[s] = 1'b1;
        exp_pkt[s]   = pkts[gl[s]];
        exp_mult[s]  = mflags[gl[s]];
      end
      if (gl.size() > 0) m_rr = (gl[gl.size()-1] + 1) % RS;
      if (took) m_mult_ok = now + ML;
    end
    exp_busy = (cyc < m_mult_ok);
  endtask

  task automatic do_reset();
    reset = 1'b1; ex_stall = 1'b0; squash = 1'b0;
    line_ready = '0; line_is_mult = '0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_stall = 1'b0; squash = 1'b0;
    line_ready = 8'hFF; line_is_mult = '0;
    randomize_pkts();
    repeat (2) begin
      cycle();
      checks++;
      if (obs_clear !== 8'h00) begin
        failures++; $display("FAIL reset_clear got=%h exp=00", obs_clear);
      end
    end
    checks++;
    if (is_valid !== '0 || is_pkt !== '0 || is_mult !== '0 || mult_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b mult=%b busy=%b pkt_nonzero=%b exp all zero",
               is_valid, is_mult, mult_busy, |is_pkt);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (obs_clear !== 8'h03 || obs_clear !== exp_clear) begin
      failures++; $display("FAIL reset_first_grant got=%h exp=03", obs_clear);
    end
    checks++;
    if (is_valid !== 2'b11 || is_pkt !== {pkts[1], pkts[0]}) begin
      failures++; $display("FAIL reset_first_issue got valid=%b exp valid=11 with lines 0,1", is_valid);
    end
    cycle();
    checks++;
    if (obs_clear !== 8'h0C) begin
      failures++; $display("FAIL reset_rr_ptr2 got=%h exp=0c", obs_clear);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    randomize_pkts();
    line_ready = 8'h03;
    cycle();
    line_ready = 8'b1000_0011;
    cycle();
    checks++;
    if (obs_clear !== 8'h81 || obs_clear !== exp_clear) begin
      failures++; $display("FAIL rr_wrap_clear got=%h exp=81", obs_clear);
    end
    checks++;
    if (is_pkt !== {pkts[0], pkts[7]} || is_valid !== 2'b11) begin
      failures++; $display("FAIL rr_wrap_slots got valid=%b exp slot0=line7 slot1=line0", is_valid);
    end
    cycle();
    checks++;
    if (obs_clear !== 8'h82) begin
      failures++; $display("FAIL rr_next_clear got=%h exp=82", obs_clear);
    end
    checks++;
    if (is_pkt !== {pkts[7], pkts[1]}) begin
      failures++; $display("FAIL rr_next_slots got=%h exp slot0=line1 slot1=line7", is_pkt[PW-1:0]);
    end
  endtask

  task automatic test_mult_hazard();
    do_reset();
    randomize_pkts();
    line_ready = 8'h07; line_is_mult = 8'h03;
    cycle();
    checks++;
    if (obs_clear !== 8'h05 || is_mult !== 2'b01 || mult_busy !== 1'b1) begin
      failures++;
      $display("FAIL mult_first got clear=%h mult=%b busy=%b exp clear=05 mult=01 busy=1",
               obs_clear, is_mult, mult_busy);
    end
    line_ready = 8'h02;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (obs_clear !== 8'h00 || mult_busy !== (k < 2) || mult_busy !== exp_busy) begin
        failures++;
        $display("FAIL mult_blocked k=%0d got clear=%h busy=%b exp clear=00 busy=%b",
                 k, obs_clear, mult_busy, (k < 2));
      end
    end
    cycle();
    checks++;
    if (obs_clear !== 8'h02 || is_mult !== 2'b01 || is_pkt[PW-1:0] !== pkts[1]) begin
      failures++; $display("FAIL mult_second got clear=%h mult=%b exp clear=02 mult=01", obs_clear, is_mult);
    end
    line_ready = '0; line_is_mult = '0;
  endtask

  task automatic test_stall();
    do_reset();
    randomize_pkts();
    line_ready = 8'h18;
    cycle();
    checks++;
    if (obs_clear !== 8'h18 || is_pkt !== {pkts[4], pkts[3]}) begin
      failures++; $display("FAIL stall_setup got clear=%h exp=18", obs_clear);
    end
    ex_stall = 1'b1; line_ready = 8'h20;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (obs_clear !== 8'h00 || is_valid !== 2'b11 || is_pkt !== {pkts[4], pkts[3]}) begin
        failures++; $display("FAIL stall_hold k=%0d got clear=%h valid=%b", k, obs_clear, is_valid);
      end
    end
    ex_stall = 1'b0;
    cycle();
    checks++;
    if (obs_clear !== 8'h20 || is_valid !== 2'b01 || is_pkt[PW-1:0] !== pkts[5]) begin
      failures++; $display("FAIL stall_resume got clear=%h valid=%b exp clear=20 valid=01", obs_clear, is_valid);
    end
    line_ready = '0;
  endtask

  task automatic test_squash();
    do_reset();
    randomize_pkts();
    line_ready = 8'h01; line_is_mult = 8'h03;
    cycle();
    squash = 1'b1; line_ready = 8'h02;
    cycle();
    checks++;
    if (obs_clear !== 8'h00 || is_valid !== 2'b00 || mult_busy !== 1'b0) begin
      failures++;
      $display("FAIL squash_flush got clear=%h valid=%b busy=%b exp 00/00/0", obs_clear, is_valid, mult_busy);
    end
    squash = 1'b0;
    cycle();
    checks++;
    if (obs_clear !== 8'h02 || is_mult !== 2'b01 || is_valid !== 2'b01) begin
      failures++; $display("FAIL squash_regrant got clear=%h mult=%b exp clear=02 mult=01", obs_clear, is_mult);
    end
    line_ready = 8'h04; line_is_mult = '0; ex_stall = 1'b1; squash = 1'b1;
    cycle();
    checks++;
    if (obs_clear !== 8'h00 || is_valid !== 2'b00) begin
      failures++; $display("FAIL squash_over_stall got clear=%h valid=%b exp 00/00", obs_clear, is_valid);
    end
    ex_stall = 1'b0; squash = 1'b0; line_ready = '0;
  endtask

  task automatic test_packet_integrity();
    do_reset();
    randomize_pkts();
    exp_q = {};
    for (int i = 0; i < RS; i++) exp_q.push_back(pkts[i]);
    line_ready = 8'hFF; line_is_mult = '0;
    repeat (4) begin
      cycle();
      line_ready = line_ready & ~obs_clear;
      for (int s = 0; s < IW; s++) begin
        if (is_valid[s]) begin
          logic [PW-1:0] want;
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL pkt_extra slot=%0d got=%h exp none", s, is_pkt[s*PW +: PW]);
          end else begin
            want = exp_q.pop_front();
            if (is_pkt[s*PW +: PW] !== want) begin
              failures++; $display("FAIL pkt_order slot=%0d got=%h exp=%h", s, is_pkt[s*PW +: PW], want);
            end
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL pkt_missing got_left=%0d exp=0", exp_q.size());
    end
    line_ready = '0;
  endtask

  task automatic test_random();
    do_reset();
    randomize_pkts();
    for (int t = 0; t < 600; t++) begin
      line_ready   = RS'($urandom());
      line_is_mult = RS'($urandom() & $urandom());
      ex_stall     = ($urandom_range(0, 5) == 0);
      squash       = ($urandom_range(0, 11) == 0);
      reset        = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) randomize_pkts();
      cycle();
      checks++;
      if (obs_clear !== exp_clear) begin
        failures++; $display("FAIL rand_clear t=%0d got=%h exp=%h", t, obs_clear, exp_clear);
      end
      checks++;
      if (is_valid !== exp_valid || mult_busy !== exp_busy) begin
        failures++;
        $display("FAIL rand_state t=%0d got valid=%b busy=%b exp valid=%b busy=%b",
                 t, is_valid, mult_busy, exp_valid, exp_busy);
      end
      for (int s = 0; s < IW; s++) begin
        if (exp_valid[s]) begin
          checks++;
          if (is_pkt[s*PW +: PW] !== exp_pkt[s] || is_mult[s] !== exp_mult[s]) begin
            failures++;
            $display("FAIL rand_slot t=%0d s=%0d got mult=%b pkt=%h exp mult=%b pkt=%h",
                     t, s, is_mult[s], is_pkt[s*PW +: PW], exp_mult[s], exp_pkt[s]);
          end
        end
      end
    end
    reset = 1'b0; ex_stall = 1'b0; squash = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ex_stall = 1'b0; squash = 1'b0;
    line_ready = '0; line_is_mult = '0; line_pkt = '0;
    for (int s = 0; s < IW; s++) exp_pkt[s] = '0;
    #1;
    test_reset();
    test_round_robin();
    test_mult_hazard();
    test_stall();
    test_squash();
    test_packet_integrity();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
